// File: rtl/compare_result_tracker.sv
// compare_result_tracker: per-frame outcome counts and operand extremes for a magnitude comparator stream
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 opens a new frame while idle
//   in_valid / in_ready   sample handshake for a, b, igual/menor/maior, last
//   out_valid / out_ready frame summary handshake
//   cnt_igual/menor/maior saturating outcome counters (CW bits)
//   max_val / min_val     running extremes of the larger/smaller operand (W bits)
//   erro                  sticky invalid-flag indicator for the frame
//
// Optional: define CMP_CROSSCHECK_EN to verify the one-hot flags against a local compare of a and b.
module compare_result_tracker #(
    parameter int unsigned W  = 4,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          igual,
    input  logic          menor,
    input  logic          maior,
    input  logic          last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] cnt_igual,
    output logic [CW-1:0] cnt_menor,
    output logic [CW-1:0] cnt_maior,
    output logic [W-1:0]  max_val,
    output logic [W-1:0]  min_val,
    output logic          erro
);
    typedef enum logic [1:0] {IDLE, ACUM, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_ig_q, cnt_ig_d, cnt_me_q, cnt_me_d, cnt_ma_q, cnt_ma_d;
    logic [W-1:0]  max_q, max_d, min_q, min_d;
    logic          erro_q, erro_d, seen_q, seen_d;
    logic          agree, valid_s;
    logic [W-1:0]  larger, smaller;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

`ifdef CMP_CROSSCHECK_EN
    assign agree = (igual == (a == b)) && (menor == (a < b)) && (maior == (a > b));
`else
    assign agree = 1'b1;
`endif

    assign valid_s = $onehot({igual, menor, maior}) && agree;
    // igual selects a for both extremes; menor falls through to b as the larger operand
    assign larger  = (maior || igual) ? a : b;
    assign smaller = maior ? b : a;

    always_comb begin
        state_d   = state_q;
        cnt_ig_d  = cnt_ig_q;
        cnt_me_d  = cnt_me_q;
        cnt_ma_d  = cnt_ma_q;
        max_d     = max_q;
        min_d     = min_q;
        erro_d    = erro_q;
        seen_d    = seen_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ACUM;
                    cnt_ig_d = '0;
                    cnt_me_d = '0;
                    cnt_ma_d = '0;
                    max_d    = '0;
                    min_d    = '0;
                    erro_d   = 1'b0;
                    seen_d   = 1'b0;
                end
            end
            ACUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (valid_s) begin
                        cnt_ig_d = igual ? sat_inc(cnt_ig_q) : cnt_ig_q;
                        cnt_me_d = menor ? sat_inc(cnt_me_q) : cnt_me_q;
                        cnt_ma_d = maior ? sat_inc(cnt_ma_q) : cnt_ma_q;
                        max_d    = (!seen_q || larger > max_q) ? larger : max_q;
                        min_d    = (!seen_q || smaller < min_q) ? smaller : min_q;
                        seen_d   = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                    state_d = last ? DONE : ACUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                state_d   = out_ready ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_ig_q <= '0;
            cnt_me_q <= '0;
            cnt_ma_q <= '0;
            max_q    <= '0;
            min_q    <= '0;
            erro_q   <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_ig_q <= cnt_ig_d;
            cnt_me_q <= cnt_me_d;
            cnt_ma_q <= cnt_ma_d;
            max_q    <= max_d;
            min_q    <= min_d;
            erro_q   <= erro_d;
            seen_q   <= seen_d;
        end
    end

    assign cnt_igual = cnt_ig_q;
    assign cnt_menor = cnt_me_q;
    assign cnt_maior = cnt_ma_q;
    assign max_val   = max_q;
    assign min_val   = min_q;
    assign erro      = erro_q;
endmodule

// File: tb/tb_compare_result_tracker.sv
// tb_compare_result_tracker: directed and randomized frames checked against a queue-based reference model
module tb_compare_result_tracker;
    localparam int W = 4, CW = 8;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic igual = 1'b0, menor = 1'b0, maior = 1'b0, last = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, erro;
    logic [CW-1:0] cnt_igual, cnt_menor, cnt_maior;
    logic [W-1:0] max_val, min_val;

    compare_result_tracker #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .igual(igual), .menor(menor), .maior(maior), .last(last),
        .out_valid(out_valid), .out_ready(out_ready),
        .cnt_igual(cnt_igual), .cnt_menor(cnt_menor), .cnt_maior(cnt_maior),
        .max_val(max_val), .min_val(min_val), .erro(erro)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int m_ig, m_me, m_ma;
    bit m_err;
    int big_q[$], small_q[$];

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    function automatic int m_max();
        int r = 0;
        foreach (big_q[i]) if (big_q[i] > r) r = big_q[i];
        return r;
    endfunction

    function automatic int m_min();
        int r = (1 << W) - 1;
        if (small_q.size() == 0) return 0;
        foreach (small_q[i]) if (small_q[i] < r) r = small_q[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_ig = 0; m_me = 0; m_ma = 0; m_err = 0;
        big_q.delete(); small_q.delete();
    endtask

    task automatic chk_all(input string tag, input bit ov, input bit ir);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".cnt_igual"}, 32'(cnt_igual), 32'(sat(m_ig)));
        chk({tag, ".cnt_menor"}, 32'(cnt_menor), 32'(sat(m_me)));
        chk({tag, ".cnt_maior"}, 32'(cnt_maior), 32'(sat(m_ma)));
        chk({tag, ".max_val"}, 32'(max_val), 32'(m_max()));
        chk({tag, ".min_val"}, 32'(min_val), 32'(m_min()));
        chk({tag, ".erro"}, 32'(erro), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_clear();
        chk_all("start", 1'b0, 1'b1);
    endtask

    task automatic send(input int av, input int bv, input bit ig, input bit me, input bit ma,
                        input bit lst, input bit full_chk);
        bit ok;
        a = W'(av); b = W'(bv); igual = ig; menor = me; maior = ma; last = lst;
        in_valid = 1'b1;
        start = 1'($urandom_range(0, 1));
        tick();
        in_valid = 1'b0; last = 1'b0; start = 1'b0;
        ok = (int'(ig) + int'(me) + int'(ma)) == 1;
`ifdef CMP_CROSSCHECK_EN
        ok = ok && (ig == (av == bv)) && (me == (av < bv)) && (ma == (av > bv));
`endif
        if (ok) begin
            if (ig) m_ig++;
            if (me) m_me++;
            if (ma) m_ma++;
            big_q.push_back((ma || ig) ? av : bv);
            small_q.push_back(ma ? bv : av);
        end else begin
            m_err = 1'b1;
        end
        if (full_chk || lst) chk_all("sample", lst, !lst);
    endtask

    task automatic finish_frame(input int hold);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            start = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            last = 1'b1;
            tick();
            chk_all("done_hold", 1'b1, 1'b0);
        end
        start = 1'b0; in_valid = 1'b0; last = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_all("to_idle", 1'b0, 1'b0);
    endtask

    task automatic rand_sample(input bit lst);
        int av, bv, mode;
        bit ig, me, ma;
        av = $urandom_range(0, (1 << W) - 1);
        bv = $urandom_range(0, (1 << W) - 1);
        mode = $urandom_range(0, 9);
        ig = (av == bv); me = (av < bv); ma = (av > bv);
        if (mode == 0) begin
            ig = 0; me = 0; ma = 0;
        end else if (mode == 1) begin
            ig = 1; ma = 1;
        end else if (mode == 2) begin
            {ig, me, ma} = 3'b001 << $urandom_range(0, 2);
        end
        send(av, bv, ig, me, ma, lst, 1'b1);
    endtask

    initial begin
        m_clear();
        #12;
        chk_all("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 1'b0, 1'b0);

        // reset mid-frame aborts it
        do_start();
        send(3, 5, 0, 1, 0, 0, 1'b1);
        send(9, 2, 0, 0, 1, 0, 1'b1);
        rst_n = 1'b0;
        m_clear();
        tick();
        chk_all("rst_mid", 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("rst_after", 1'b0, 1'b0);

        // basic three-outcome frame
        do_start();
        send(3, 5, 0, 1, 0, 0, 1'b1);
        send(9, 2, 0, 0, 1, 0, 1'b1);
        send(7, 7, 1, 0, 0, 1, 1'b1);
        chk("basic.max_const", 32'(max_val), 32'd9);
        chk("basic.min_const", 32'(min_val), 32'd2);
        finish_frame(5);
        chk("idle_retain.max", 32'(max_val), 32'd9);

        // saturation
        do_start();
        for (int i = 0; i < 300; i++) send(1, 1, 1, 0, 0, i == 299, 1'b0);
        chk("sat.cnt_igual", 32'(cnt_igual), 32'd255);
        finish_frame(0);

        // invalid flag set then valid last sample
        do_start();
        send(4, 4, 1, 0, 1, 0, 1'b1);
        send(6, 1, 0, 0, 1, 1, 1'b1);
        chk("inv.erro", 32'(erro), 32'd1);
        chk("inv.max", 32'(max_val), 32'd6);
        finish_frame(2);

        // frame of only invalid samples
        do_start();
        send(5, 3, 0, 0, 0, 0, 1'b1);
        send(2, 2, 1, 1, 1, 1, 1'b1);
        finish_frame(1);

        // boundary operands
        do_start();
        send(0, 15, 0, 1, 0, 0, 1'b1);
        send(15, 0, 0, 0, 1, 1, 1'b1);
        finish_frame(1);

        // flags disagreeing with the operands
        do_start();
        send(2, 8, 0, 0, 1, 1, 1'b1);
`ifdef CMP_CROSSCHECK_EN
        chk("xchk.erro", 32'(erro), 32'd1);
        chk("xchk.cnt_maior", 32'(cnt_maior), 32'd0);
`else
        chk("xchk.cnt_maior", 32'(cnt_maior), 32'd1);
        chk("xchk.max", 32'(max_val), 32'd2);
        chk("xchk.min", 32'(min_val), 32'd8);
`endif
        finish_frame(0);

        // randomized frames with gaps
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 20);
            do_start();
            for (int s = 0; s < len; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    chk_all("gap", 1'b0, 1'b1);
                end
                rand_sample(s == len - 1);
            end
            finish_frame($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
